// File: rtl/qam_tx_pkg.sv
// Shared types and constants for the QAM transmit framing controller.
package qam_tx_pkg;

    localparam int unsigned LEN_W           = 11;
    localparam int unsigned MAX_FRAME_LEN   = 1024;
    localparam int unsigned DEF_PRE_LEN     = 16;
    localparam logic [63:0] DEF_PRE_PATTERN = 64'hA5A5;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StPayload,
        StFlush,
        StDone
    } state_t;

    // Frames must carry whole symbols, so the length has to be even and non-zero.
    function automatic logic len_ok(input logic [31:0] len);
        return (len != 32'd0) && !len[0] && (len <= MAX_FRAME_LEN);
    endfunction

endpackage

// File: rtl/qam_preamble_gen.sv
// Preamble source: loadable shift register emitting the pattern MSB first,
// with a bit counter flagging the final preamble bit.
module qam_preamble_gen #(
    parameter int unsigned PRE_LEN     = 16,
    parameter logic [63:0] PRE_PATTERN = 64'hA5A5
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic shift,
    output logic pre_bit,
    output logic last
);

    logic [PRE_LEN-1:0] sr_q;
    logic [6:0]         cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sr_q  <= PRE_PATTERN[PRE_LEN-1:0];
            cnt_q <= '0;
        end else if (shift) begin
            sr_q  <= sr_q << 1;
            cnt_q <= cnt_q + 7'd1;
        end
    end

    assign pre_bit = sr_q[PRE_LEN-1];
    assign last    = (cnt_q == 7'(PRE_LEN - 1));

endmodule

// File: rtl/qam_tx_ctrl.sv
// Frame controller feeding a 2-bit serial-to-parallel converter: preamble,
// payload with upstream handshake, then a flush and a done cycle.
module qam_tx_ctrl
    import qam_tx_pkg::*;
#(
    parameter int unsigned PRE_LEN     = DEF_PRE_LEN,
    parameter logic [63:0] PRE_PATTERN = DEF_PRE_PATTERN,
    parameter int unsigned LEN_W       = qam_tx_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             spc_en,
    output logic             spc_din,
    output logic             sym_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             len_err
);

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             parity_q;
    logic             sym_valid_q;
    logic             len_err_q;
    logic             pre_bit;
    logic             pre_last;
    logic             start_idle;
    logic             accept;
    logic             xfer;

    assign start_idle = (state_q == StIdle) && start;
    assign accept     = start_idle && len_ok(32'(frame_len));
    assign xfer       = (state_q == StPayload) && bit_valid;

    qam_preamble_gen #(
        .PRE_LEN     (PRE_LEN),
        .PRE_PATTERN (PRE_PATTERN)
    ) u_pre (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift   (state_q == StPreamble),
        .pre_bit (pre_bit),
        .last    (pre_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            parity_q    <= 1'b0;
            sym_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            // Parity tracks which half of a symbol the next enabled bit fills.
            sym_valid_q <= spc_en && parity_q;
            if (spc_en) begin
                parity_q <= ~parity_q;
            end
            len_err_q <= start_idle && !accept;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q  <= StPreamble;
                        len_q    <= frame_len;
                        cnt_q    <= '0;
                        parity_q <= 1'b0;
                    end
                end
                StPreamble: begin
                    if (pre_last) begin
                        state_q <= StPayload;
                    end
                end
                StPayload: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bit_ready  = (state_q == StPayload);
    assign spc_en     = (state_q == StPreamble) || xfer;
    assign spc_din    = (state_q == StPreamble) ? pre_bit : (xfer && bit_in);
    assign sym_valid  = sym_valid_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);
    assign len_err    = len_err_q;

endmodule

// File: doc/qam_tx_ctrl.md
QAM_TX_CTRL -- requirements
Module: qam_tx_ctrl

Interface
REQ-001 SHALL have parameter PRE_LEN, default 16, meaning preamble length in bits (even, 2..64).
REQ-002 SHALL have parameter PRE_PATTERN, default 16'hA5A5, meaning preamble bits, sent MSB first.
REQ-003 SHALL have parameter LEN_W, default 11, meaning frame_len width.
REQ-004 SHALL have port clk  in  1  system clock, rising-edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle frame request.
REQ-007 SHALL have port frame_len  in  LEN_W  payload length in bits, sampled on accepted start.
REQ-008 SHALL have port bit_valid  in  1  upstream payload bit valid.
REQ-009 SHALL have port bit_in  in  1  upstream payload bit.
REQ-010 SHALL have port bit_ready  out  1  controller accepts payload bit this cycle.
REQ-011 SHALL have port spc_en  out  1  enable to serial-to-parallel converter.
REQ-012 SHALL have port spc_din  out  1  serial bit to converter, valid when spc_en=1.
REQ-013 SHALL have port sym_valid  out  1  converter 2-bit output holds a new complete symbol.
REQ-014 SHALL have port busy  out  1  frame in progress.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse at end of frame.
REQ-016 SHALL have port len_err  out  1  one-cycle pulse on rejected start.

Function
REQ-017 SHALL implement FSM states IDLE, PREAMBLE, PAYLOAD, FLUSH, DONE.
REQ-018 SHALL, in IDLE, accept start only when frame_len is even and in 2..1024; accepted start moves to PREAMBLE next cycle.
REQ-019 SHALL, on start with odd, zero or >1024 frame_len, pulse len_err the next cycle and remain IDLE.
REQ-020 SHALL ignore start in any state other than IDLE (no len_err, no restart).
REQ-021 SHALL, in PREAMBLE, assert spc_en every cycle and drive PRE_PATTERN bits MSB first, exactly PRE_LEN cycles, then enter PAYLOAD.
REQ-022 SHALL, in PAYLOAD, drive bit_ready=1; a bit transfers when bit_valid&bit_ready, and only then spc_en=1, spc_din=bit_in (combinational pass-through, same cycle).
REQ-023 SHALL, when bit_valid=0 in PAYLOAD, hold spc_en=0 and preserve symbol pairing across the stall.
REQ-024 SHALL count transferred payload bits in a LEN_W counter; on transfer of bit frame_len-1, deassert bit_ready from the next cycle and enter FLUSH.
REQ-025 SHALL assert sym_valid in the cycle after every second enabled bit (bit indices 1,3,5,... counted from first preamble bit), never otherwise.
REQ-026 SHALL spend exactly one cycle in FLUSH (carrying the final sym_valid), then one cycle in DONE with frame_done=1, then return to IDLE.
REQ-027 SHALL hold busy=1 in PREAMBLE, PAYLOAD, FLUSH, DONE and 0 in IDLE.
REQ-028 SHALL produce exactly (PRE_LEN+frame_len)/2 sym_valid pulses per frame.
REQ-029 SHALL accept a start in the cycle after DONE (back-to-back frames, no extra gap).
REQ-030 SHALL keep bit_ready=0 in all states except PAYLOAD.

Reset
REQ-031 SHALL, on rst=0, immediately force IDLE and all outputs (bit_ready, spc_en, spc_din, sym_valid, busy, frame_done, len_err) to 0, clearing counters and pairing parity, including mid-frame.
REQ-032 SHALL, after rst release, require a new start; the aborted frame is not resumed.

Structure
REQ-033 SHALL place the state enum, LEN_W, MAX_FRAME_LEN=1024 and default PRE_LEN/PRE_PATTERN in shared package qam_tx_pkg.
REQ-034 SHALL use one sub-module, qam_preamble_gen (loadable shift register plus count, outputs current bit and last flag).

Verification
REQ-035 SHALL cover: rst=0 for 10 cycles -> all outputs 0, busy=0.
REQ-036 SHALL cover: start, frame_len=8, bit_valid always 1, data 10110010 -> 16 spc_din cycles A5A5 MSB first, then 8 payload bits, 12 sym_valid pulses, frame_done 26 cycles after start+1.
REQ-037 SHALL cover: frame_len=8 with bit_valid low on alternate payload cycles -> spc_en low in gaps, still 12 sym_valid, pairs {1,0},{1,1},{0,0},{1,0}.
REQ-038 SHALL cover: start with frame_len=7, then 0, then 1026 -> three len_err pulses, busy stays 0.
REQ-039 SHALL cover: start again during PAYLOAD, and rst=0 at payload bit 3 -> start ignored; after reset all outputs 0, no frame_done, next start with frame_len=2 completes with 9 sym_valid.
REQ-040 SHALL cover: two back-to-back frames of frame_len=1024 -> start accepted the cycle after DONE, 520 sym_valid each.
